multdiv_ctrl: RTL and testbench

Pipeline-side sequencer for the team's iterative multdiv unit.
- Accepts one MULT/DIV request from the execute stage and holds operands stable for the whole operation, since multdiv re-latches its operands every clock.
- Issues a single-cycle ctrl_MULT/ctrl_DIV pulse and stalls the pipeline until data_resultRDY.
- Delivers result, exception and destination register to writeback as a one-cycle valid pulse.
- Adds flush (abort) and a watchdog timeout.

---
 rtl/multdiv_ctrl.sv | 178 +++++++++++++++++
 tb/tb_multdiv_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_ctrl.sv
// rtl/multdiv_ctrl.sv - pipeline-side sequencer for the iterative multdiv unit
//
// Purpose:
//   Accepts one MULT/DIV request from execute and holds its operands steady
//   for the whole operation, because multdiv re-latches them every clock.
//   Issues a single-cycle start pulse, then stalls the pipeline until
//   multdiv reports a result. Hands result, exception and destination
//   register to writeback with a one-cycle valid strobe. A flush aborts the
//   operation. A watchdog forces completion with an exception if multdiv
//   never answers.
//
// Ports:
//   i_clock, i_reset_n          clock (rising edge), async active-low reset
//   i_req_valid/is_div/a/b/rd   request from execute
//   i_flush                     abort in-flight op / block acceptance / kill wb
//   o_md_operandA/B             held operands to multdiv
//   o_md_ctrl_mult/div          one-cycle start pulse to multdiv
//   i_md_result/exception/RDY   multdiv result interface
//   o_stall                     freeze fetch/decode/execute
//   o_wb_valid/rd/data/exception writeback strobe and payload

module multdiv_ctrl #(
  parameter int MIN_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_req_valid,
  input  logic        i_req_is_div,
  input  logic [31:0] i_req_a,
  input  logic [31:0] i_req_b,
  input  logic [4:0]  i_req_rd,
  input  logic        i_flush,
  output logic [31:0] o_md_operandA,
  output logic [31:0] o_md_operandB,
  output logic        o_md_ctrl_mult,
  output logic        o_md_ctrl_div,
  input  logic [31:0] i_md_result,
  input  logic        i_md_exception,
  input  logic        i_md_resultRDY,
  output logic        o_stall,
  output logic        o_wb_valid,
  output logic [4:0]  o_wb_rd,
  output logic [31:0] o_wb_data,
  output logic        o_wb_exception
);

  // Counter must be able to hold TIMEOUT itself, since it saturates there.
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] C_MIN      = CW'(MIN_CYCLES);
  localparam logic [CW-1:0] C_TO       = CW'(TIMEOUT);
  localparam logic [CW-1:0] C_TO_LAST  = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic [31:0]   r_op_a;
  logic [31:0]   r_op_b;
  logic [4:0]    r_rd;
  logic          r_op_div;
  logic [31:0]   r_wb_data;
  logic          r_wb_exc;
  logic [CW-1:0] r_cnt;

  logic          w_accept;
  logic          w_rdy_ok;
  logic          w_capture;
  logic          w_timeout;

  // RDY is only trusted once the minimum busy time has elapsed; an earlier
  // RDY may be left over from the previous operation.
  assign w_rdy_ok = i_md_resultRDY && (r_cnt >= C_MIN);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_req_valid && !i_flush) begin
          w_accept = 1'b1;
          w_next   = S_START;
        end
      end
      S_START: begin
        w_next = i_flush ? S_IDLE : S_BUSY;
      end
      S_BUSY: begin
        // Flush beats a simultaneous RDY: the instruction is gone.
        if (i_flush) begin
          w_next = S_IDLE;
        end else if (w_rdy_ok) begin
          w_capture = 1'b1;
          w_next    = S_DONE;
        end else if (r_cnt >= C_TO_LAST) begin
          // This is the TIMEOUT-th busy cycle with no qualifying RDY.
          w_timeout = 1'b1;
          w_next    = S_DONE;
        end
      end
      S_DONE: begin
        // Never accept here: the instruction in execute this cycle is the
        // one just completed, so accepting would issue it twice.
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Operand / destination latch: changes only on acceptance.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_rd     <= '0;
      r_op_div <= 1'b0;
    end else if (w_accept) begin
      r_op_a   <= i_req_a;
      r_op_b   <= i_req_b;
      r_rd     <= i_req_rd;
      r_op_div <= i_req_is_div;
    end
  end

  // Result capture: holds until the next completion.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wb_data <= '0;
      r_wb_exc  <= 1'b0;
    end else if (w_capture) begin
      r_wb_data <= i_md_result;
      r_wb_exc  <= i_md_exception;
    end else if (w_timeout) begin
      r_wb_data <= '0;
      r_wb_exc  <= 1'b1;
    end
  end

  // Busy-cycle counter: value k during the (k+1)-th BUSY cycle.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt <= '0;
    end else if (r_state == S_START) begin
      r_cnt <= '0;
    end else if ((r_state == S_BUSY) && (r_cnt < C_TO)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_md_operandA  = r_op_a;
  assign o_md_operandB  = r_op_b;
  assign o_md_ctrl_mult = (r_state == S_START) && !r_op_div;
  assign o_md_ctrl_div  = (r_state == S_START) &&  r_op_div;
  assign o_stall        = (r_state == S_START) || (r_state == S_BUSY);
  assign o_wb_valid     = (r_state == S_DONE) && !i_flush;
  assign o_wb_rd        = r_rd;
  assign o_wb_data      = r_wb_data;
  assign o_wb_exception = r_wb_exc;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb/tb_multdiv_ctrl.sv - directed self-checking bench for multdiv_ctrl

module tb_multdiv_ctrl;

  logic        clock;
  logic        reset_n;
  logic        req_valid;
  logic        req_is_div;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  req_rd;
  logic        flush;
  logic [31:0] md_operandA;
  logic [31:0] md_operandB;
  logic        md_ctrl_mult;
  logic        md_ctrl_div;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_resultRDY;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_exception;

  int checks = 0;
  int errors = 0;

  multdiv_ctrl #(.MIN_CYCLES(2), .TIMEOUT(64)) dut (
    .i_clock         (clock),
    .i_reset_n       (reset_n),
    .i_req_valid     (req_valid),
    .i_req_is_div    (req_is_div),
    .i_req_a         (req_a),
    .i_req_b         (req_b),
    .i_req_rd        (req_rd),
    .i_flush         (flush),
    .o_md_operandA   (md_operandA),
    .o_md_operandB   (md_operandB),
    .o_md_ctrl_mult  (md_ctrl_mult),
    .o_md_ctrl_div   (md_ctrl_div),
    .i_md_result     (md_result),
    .i_md_exception  (md_exception),
    .i_md_resultRDY  (md_resultRDY),
    .o_stall         (stall),
    .o_wb_valid      (wb_valid),
    .o_wb_rd         (wb_rd),
    .o_wb_data       (wb_data),
    .o_wb_exception  (wb_exception)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic present(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
    req_valid  = 1'b1;
    req_is_div = is_div;
    req_a      = a;
    req_b      = b;
    req_rd     = rd;
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_is_div = 1'b0; req_a = '0; req_b = '0;
    req_rd = '0; flush = 1'b0; md_result = '0; md_exception = 1'b0; md_resultRDY = 1'b0;

    // Reset state
    #2;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_ctrl", {30'd0, md_ctrl_mult, md_ctrl_div}, 0);
    chk("rst_opA", md_operandA, 0);
    chk("rst_wb_data", wb_data, 0);
    #10 reset_n = 1'b1;
    tick();

    // 1: mult 7*6 -> 42, rd 3
    present(1'b0, 32'd7, 32'd6, 5'd3);
    tick();                                  // START
    req_valid = 1'b0;
    chk("t1_mult_pulse", 32'(md_ctrl_mult), 1);
    chk("t1_div_pulse", 32'(md_ctrl_div), 0);
    chk("t1_stall_start", 32'(stall), 1);
    chk("t1_opA", md_operandA, 7);
    chk("t1_opB", md_operandB, 6);
    tick();                                  // BUSY0
    chk("t1_pulse_once", 32'(md_ctrl_mult), 0);
    chk("t1_stall_busy", 32'(stall), 1);
    tick(); tick();                          // BUSY2
    md_result = 32'd42; md_resultRDY = 1'b1;
    tick();                                  // DONE
    md_resultRDY = 1'b0;
    chk("t1_wb_valid", 32'(wb_valid), 1);
    chk("t1_wb_data", wb_data, 42);
    chk("t1_wb_rd", 32'(wb_rd), 3);
    chk("t1_wb_exc", 32'(wb_exception), 0);
    chk("t1_stall_done", 32'(stall), 0);
    tick();                                  // IDLE
    chk("t1_wb_one_cycle", 32'(wb_valid), 0);

    // 2: div 100/0 -> exception; stale RDY high from BUSY0 is masked
    present(1'b1, 32'd100, 32'd0, 5'd9);
    tick();                                  // START
    req_valid = 1'b0;
    chk("t2_div_pulse", 32'(md_ctrl_div), 1);
    chk("t2_mult_pulse", 32'(md_ctrl_mult), 0);
    tick();                                  // BUSY0
    md_result = 32'd0; md_exception = 1'b1; md_resultRDY = 1'b1;
    tick();                                  // BUSY1 (RDY ignored)
    chk("t2_mask0_stall", 32'(stall), 1);
    chk("t2_mask0_wb", 32'(wb_valid), 0);
    tick();                                  // BUSY2 (RDY ignored)
    chk("t2_mask1_stall", 32'(stall), 1);
    chk("t2_mask1_wb", 32'(wb_valid), 0);
    tick();                                  // DONE
    md_resultRDY = 1'b0; md_exception = 1'b0;
    chk("t2_wb_valid", 32'(wb_valid), 1);
    chk("t2_wb_data", wb_data, 0);
    chk("t2_wb_exc", 32'(wb_exception), 1);
    chk("t2_wb_rd", 32'(wb_rd), 9);
    tick();                                  // IDLE

    // 3: req_valid held through stall, then div 100/7 presented in DONE
    present(1'b0, 32'd3, 32'd5, 5'd1);
    tick();                                  // START
    chk("t3_mult_pulse", 32'(md_ctrl_mult), 1);
    tick(); tick(); tick();                  // BUSY2
    md_result = 32'd15; md_resultRDY = 1'b1;
    tick();                                  // DONE
    md_resultRDY = 1'b0;
    chk("t3_first_wb", 32'(wb_valid), 1);
    chk("t3_first_data", wb_data, 15);
    present(1'b1, 32'd100, 32'd7, 5'd10);
    tick();                                  // IDLE: nothing accepted in DONE
    chk("t3_idle_stall", 32'(stall), 0);
    chk("t3_idle_nopulse", 32'(md_ctrl_div), 0);
    chk("t3_idle_wb", 32'(wb_valid), 0);
    chk("t3_opA_held", md_operandA, 3);
    tick();                                  // START of second op
    req_valid = 1'b0;
    chk("t3_div_pulse", 32'(md_ctrl_div), 1);
    chk("t3_opA_new", md_operandA, 100);
    chk("t3_opB_new", md_operandB, 7);
    tick(); tick(); tick();                  // BUSY2
    md_result = 32'd14; md_resultRDY = 1'b1;
    tick();                                  // DONE
    md_resultRDY = 1'b0;
    chk("t3_second_wb", 32'(wb_valid), 1);
    chk("t3_second_data", wb_data, 14);
    chk("t3_second_rd", 32'(wb_rd), 10);
    tick();                                  // IDLE

    // 4: flush on 5th BUSY cycle of mult 3*4
    present(1'b0, 32'd3, 32'd4, 5'd4);
    tick();                                  // START
    req_valid = 1'b0;
    tick(); tick(); tick(); tick(); tick();  // BUSY4 = 5th busy cycle
    flush = 1'b1;
    tick();                                  // IDLE
    flush = 1'b0;
    chk("t4_stall", 32'(stall), 0);
    chk("t4_wb", 32'(wb_valid), 0);
    md_result = 32'd12; md_resultRDY = 1'b1;
    tick();
    chk("t4_late_rdy_wb", 32'(wb_valid), 0);
    chk("t4_no_repulse", {30'd0, md_ctrl_mult, md_ctrl_div}, 0);
    tick();
    chk("t4_late_rdy_wb2", 32'(wb_valid), 0);
    chk("t4_stall2", 32'(stall), 0);
    md_resultRDY = 1'b0;

    // 5: flush in IDLE blocks acceptance, then watchdog timeout
    present(1'b1, 32'd9, 32'd3, 5'd5);
    flush = 1'b1;
    tick();
    chk("t5_flush_blocks", 32'(stall), 0);
    chk("t5_flush_nopulse", 32'(md_ctrl_div), 0);
    flush = 1'b0;
    tick();                                  // START
    req_valid = 1'b0;
    chk("t5_div_pulse", 32'(md_ctrl_div), 1);
    md_result = 32'hDEAD;
    for (int i = 0; i < 64; i++) tick();     // BUSY0 .. BUSY63
    chk("t5_busy63_stall", 32'(stall), 1);
    chk("t5_busy63_wb", 32'(wb_valid), 0);
    tick();                                  // DONE by timeout
    chk("t5_to_wb", 32'(wb_valid), 1);
    chk("t5_to_data", wb_data, 0);
    chk("t5_to_exc", 32'(wb_exception), 1);
    chk("t5_to_rd", 32'(wb_rd), 5);
    tick();                                  // IDLE

    // 6: asynchronous reset mid-BUSY
    present(1'b0, 32'd8, 32'd8, 5'd7);
    tick();                                  // START
    req_valid = 1'b0;
    tick(); tick();                          // BUSY1
    #3 reset_n = 1'b0;
    #1;
    chk("t6_stall", 32'(stall), 0);
    chk("t6_opA", md_operandA, 0);
    chk("t6_wb_rd", 32'(wb_rd), 0);
    chk("t6_wb_exc", 32'(wb_exception), 0);
    chk("t6_ctrl", {30'd0, md_ctrl_mult, md_ctrl_div}, 0);
    md_result = 32'd64; md_resultRDY = 1'b1;
    #2 reset_n = 1'b1;
    tick();
    chk("t6_no_wb", 32'(wb_valid), 0);
    chk("t6_idle", 32'(stall), 0);
    tick();
    chk("t6_no_wb2", 32'(wb_valid), 0);
    md_resultRDY = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
